// File: rtl/signed_sat_pkg.sv
// rtl/signed_sat_pkg.sv - shared types and saturating add/sub arithmetic
package signed_sat_pkg;

   // Widest operand the shared arithmetic supports; callers sign-extend into it.
   localparam int MAX_W = 64;

   typedef struct packed {
      logic sub;
      logic sat_en;
   } op_t;

   typedef struct packed {
      logic [MAX_W-1:0] res;
      logic             ovf_pos;
      logic             ovf_neg;
   } addsub_t;

   function automatic logic signed [MAX_W:0] sat_max(input int w);
      logic signed [MAX_W:0] one;
      one = 1;
      return (one << (w - 1)) - one;
   endfunction

   function automatic logic signed [MAX_W:0] sat_min(input int w);
      logic signed [MAX_W:0] one;
      one = 1;
      return -(one << (w - 1));
   endfunction

   // Operands arrive sign-extended to MAX_W; the MAX_W+1 sum is exact,
   // so the flags describe the true result even for A - MIN.
   function automatic addsub_t sat_addsub(input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input logic sub,
                                          input logic sat_en,
                                          input int w);
      logic signed [MAX_W:0] ea, eb, sum, hi, lo;
      addsub_t r;
      ea = {a[MAX_W-1], a};
      eb = {b[MAX_W-1], b};
      sum = sub ? ea - eb : ea + eb;
      hi = sat_max(w);
      lo = sat_min(w);
      r.ovf_pos = sum > hi;
      r.ovf_neg = sum < lo;
      if (sat_en && r.ovf_pos)
         r.res = hi[MAX_W-1:0];
      else if (sat_en && r.ovf_neg)
         r.res = lo[MAX_W-1:0];
      else
         r.res = sum[MAX_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/signed_sat_stage.sv
// rtl/signed_sat_stage.sv - generic valid/ready register slice
import signed_sat_pkg::*;

module signed_sat_stage #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data
);

   logic load;

   assign load     = !out_valid || out_ready;
   // Ready is forced high in reset; anything offered is dropped by the reset branch.
   assign in_ready = rst || load;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= in_valid;
         if (in_valid)
            out_data <= in_data;
      end
   end

endmodule

// File: rtl/signed_sat_add_pipe.sv
// rtl/signed_sat_add_pipe.sv - two-stage signed add/sub with saturation and overflow counter
import signed_sat_pkg::*;

module signed_sat_add_pipe #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             sub,
   input  logic             sat_en,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [W-1:0]     res,
   output logic             ovf_pos,
   output logic             ovf_neg,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] sat_cnt
);

   localparam int S1_W = 2 * W + $bits(op_t);
   localparam int S2_W = W + 2;

   op_t                   up_op, s1_op;
   logic [S1_W-1:0]       s1_in, s1_out;
   logic [S2_W-1:0]       s2_in, s2_out;
   logic [W-1:0]          s1_a, s1_b;
   logic                  s1_valid, s2_ready;
   logic [MAX_W-1:0]      ext_a, ext_b;
   addsub_t               calc;
   logic                  unused_calc;
   logic                  cnt_max;

   assign up_op = '{sub: sub, sat_en: sat_en};
   assign s1_in = {a, b, up_op};

   signed_sat_stage #(.PW(S1_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_out)
   );

   assign {s1_a, s1_b, s1_op} = s1_out;

   always_comb begin
      ext_a = MAX_W'($signed(s1_a));
      ext_b = MAX_W'($signed(s1_b));
      calc  = sat_addsub(ext_a, ext_b, s1_op.sub, s1_op.sat_en, W);
   end

   // Only the low W result bits are carried into the second stage.
   assign unused_calc = ^calc.res;
   assign s2_in       = {calc.res[W-1:0], calc.ovf_pos, calc.ovf_neg};

   signed_sat_stage #(.PW(S2_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (s2_in),
      .out_valid (down_valid),
      .out_ready (down_ready),
      .out_data  (s2_out)
   );

   assign {res, ovf_pos, ovf_neg} = s2_out;

   assign cnt_max = &sat_cnt;

   // Clear has priority over a coincident counted delivery.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr)
         sat_cnt <= '0;
      else if (down_valid && down_ready && (ovf_pos || ovf_neg) && !cnt_max)
         sat_cnt <= sat_cnt + 1'b1;
   end

endmodule
